// File: rtl/ifu_isram_pkg.sv
// rtl/ifu_isram_pkg.sv - shared constants, state type and address decode for the instruction SRAM slave
// Contents: AXI read response codes, reset fetch address, FSM state enum and
// decode_resp(), which classifies a byte address against a base and a window size.
package ifu_isram_pkg;

  localparam logic [1:0]  RESP_OKAY   = 2'd0;
  localparam logic [1:0]  RESP_SLVERR = 2'd2;
  localparam logic [1:0]  RESP_DECERR = 2'd3;

  localparam logic [31:0] RESET_ADDR  = 32'h8000_0000;

  typedef enum logic [1:0] {
    ISRAM_IDLE,
    ISRAM_DELAY,
    ISRAM_RESP
  } isram_state_e;

  // Misalignment wins over range. The window check uses the wrapped offset
  // so that addresses below the base fall out as large unsigned values.
  function automatic logic [1:0] decode_resp(input logic [31:0] addr,
                                             input logic [31:0] base,
                                             input logic [31:0] size_bytes);
    logic [31:0] off;
    off = addr - base;
    if (addr[1:0] != 2'b00) return RESP_SLVERR;
    if (off >= size_bytes)  return RESP_DECERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/ifu_isram_lfsr8.sv
// rtl/ifu_isram_lfsr8.sv - 8-bit Fibonacci LFSR (taps 8,6,5,4) that steps only when enabled
// Ports:
//   clk  in   clock, rising edge
//   rst  in   asynchronous active-low reset, loads seed
//   en   in   advance one step this cycle
//   seed in   [7:0] reset value, must be nonzero
//   q    out  [7:0] current register value
module lfsr8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic [7:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = {q_q[6:0], q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= seed;
    else      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/ifu_isram.sv
// rtl/ifu_isram.sv - read-only AXI-lite instruction SRAM slave with fixed or LFSR-driven latency
// Ports:
//   clk, rst                 clock (rising) and asynchronous active-low reset
//   araddr/arvalid/arready   read address channel; arready is combinational, high only in IDLE
//   rdata/rresp/rvalid/rready read data channel; rdata/rresp registered, held under backpressure
//   ld_en/ld_addr/ld_data    preload write port, same address map, illegal writes dropped
//   busy                     high whenever a transaction is in flight
module ifu_isram
  import ifu_isram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = RESET_ADDR,
  parameter int          DEPTH_WORDS  = 4096,
  parameter bit          RANDOM_DELAY = 1'b1,
  parameter int          DELAY_BITS   = 2,
  parameter int          FIXED_DELAY  = 0,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        busy
);

  localparam int          IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SIZE_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [7:0]  RAND_MASK  = 8'((1 << DELAY_BITS) - 1);
  localparam logic [7:0]  FIXED_CNT  = 8'(FIXED_DELAY);

  logic [31:0] mem [DEPTH_WORDS];

  isram_state_e state_q, state_d;
  logic [31:0]  addr_q, addr_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [31:0]  rdata_q, rdata_d;
  logic [1:0]   rresp_q, rresp_d;

  logic             ar_hs;
  logic [7:0]       lfsr_q;
  logic [1:0]       rd_resp, ld_resp;
  logic [IDX_W-1:0] rd_idx, ld_idx;

  assign arready = (state_q == ISRAM_IDLE) && rst;
  assign ar_hs   = arvalid && arready;
  assign rvalid  = (state_q == ISRAM_RESP);
  assign busy    = (state_q != ISRAM_IDLE);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  // The LFSR value used for a transaction is the one present at its handshake;
  // it then steps so the next transaction sees a fresh value.
  lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (ar_hs),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  assign rd_resp = decode_resp(addr_q, BASE_ADDR, SIZE_BYTES);
  assign rd_idx  = IDX_W'((addr_q - BASE_ADDR) >> 2);
  assign ld_resp = decode_resp(ld_addr, BASE_ADDR, SIZE_BYTES);
  assign ld_idx  = IDX_W'((ld_addr - BASE_ADDR) >> 2);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    unique case (state_q)
      ISRAM_IDLE: begin
        if (ar_hs) begin
          addr_d  = araddr;
          cnt_d   = RANDOM_DELAY ? (lfsr_q & RAND_MASK) : FIXED_CNT;
          state_d = ISRAM_DELAY;
        end
      end
      ISRAM_DELAY: begin
        // Memory is sampled on the exit edge, so preloads landing earlier in
        // the delay window are returned.
        if (cnt_q == 8'd0) begin
          state_d = ISRAM_RESP;
          rresp_d = rd_resp;
          rdata_d = (rd_resp == RESP_OKAY) ? mem[rd_idx] : 32'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ISRAM_RESP: begin
        if (rready) state_d = ISRAM_IDLE;
      end
      default: state_d = ISRAM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ISRAM_IDLE;
      addr_q  <= 32'd0;
      cnt_q   <= 8'd0;
      rdata_q <= 32'd0;
      rresp_q <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end

  // Contents survive reset so a preloaded program is kept across resets.
  always_ff @(posedge clk) begin
    if (ld_en && (ld_resp == RESP_OKAY)) mem[ld_idx] <= ld_data;
  end

endmodule

// File: doc/ifu_isram.md
Name: ifu_isram

Overview:
- AXI-lite read-only instruction SRAM slave sitting directly downstream of the instruction-fetch unit's AR/R master port. It answers the IFU's fetch requests.
- Accepts one read address, waits a fixed or pseudo-random number of cycles, then returns one 32-bit word with a response code.
- Gives the fetch stage a realistic variable-latency memory for simulation.
- Includes a side load port so benches can preload the program.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of word 0
- DEPTH_WORDS, 4096, number of 32-bit words (power of two)
- RANDOM_DELAY, 1, 1 = latency from LFSR, 0 = FIXED_DELAY
- DELAY_BITS, 2, width of the random extra-delay field (extra 0..2^DELAY_BITS-1)
- FIXED_DELAY, 0, extra delay cycles when RANDOM_DELAY=0
- LFSR_SEED, 8'hA5, nonzero LFSR reset value

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- araddr  input  32  read byte address
- arvalid  input  1  address valid
- arready  output  1  slave can accept address
- rdata  output  32  read data
- rresp  output  2  0 OKAY, 2 SLVERR (misaligned), 3 DECERR (out of range)
- rvalid  output  1  read data valid
- rready  input  1  master accepts data
- ld_en  input  1  bench preload write strobe
- ld_addr  input  32  preload byte address, same map as araddr
- ld_data  input  32  preload word
- busy  output  1  high when not IDLE

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, rvalid=0, rdata=0, rresp=0, LFSR=LFSR_SEED, delay counter=0.
  - arready=0 while rst low. Memory contents are not cleared.
- States:
  - IDLE -> DELAY on arvalid&&arready.
  - DELAY -> RESP when counter==0, else decrement.
  - RESP -> IDLE on rvalid&&rready.
- arready = (state==IDLE) && rst. It is combinational. No address is accepted outside IDLE. One outstanding transaction only.
- On AR handshake, latch araddr and load the counter:
  - RANDOM_DELAY=1: load LFSR[DELAY_BITS-1:0].
  - RANDOM_DELAY=0: load FIXED_DELAY.
- LFSR is 8-bit Fibonacci, taps 8,6,5,4. It advances once per accepted AR, never otherwise.
- Latency:
  - rvalid rises on the clock edge that exits DELAY. This is 1+extra cycles after the AR handshake edge.
  - Minimum latency is 1 cycle: with extra=0, rvalid is high the cycle after the handshake.
- Decode, evaluated on the latched address:
  - addr[1:0]!=0 -> rresp=2, rdata=0.
  - Else if addr<BASE_ADDR or addr>=BASE_ADDR+4*DEPTH_WORDS -> rresp=3, rdata=0.
  - Else rresp=0, rdata=mem[(addr-BASE_ADDR)>>2]. Index width is $clog2(DEPTH_WORDS). The subtraction wraps mod 2^32, so range checks use unsigned compares.
- rdata/rresp are registered. They are loaded when entering RESP and held stable while rvalid=1 and rready=0.
- rvalid drops on the edge after rvalid&&rready. rready held high continuously gives back-to-back operation: the next AR can be accepted the cycle after rvalid falls.
- Preload port:
  - ld_en writes mem on the clock edge, with the same alignment and range rules; illegal ld writes are ignored silently.
  - Allowed in any state. A write to the word currently being fetched in DELAY is visible in rdata, because the read happens at DELAY exit.
- Reset mid-transaction drops it: rvalid low immediately, state IDLE, and no response is ever produced for the aborted address.
- arvalid asserted during reset is ignored. It is accepted on the first clock after rst rises if still asserted.
- busy = (state!=IDLE).

Decomposition:
- Shared package (e.g. npc_pkg): AXI rresp constants RESP_OKAY=2'd0, RESP_SLVERR=2'd2, RESP_DECERR=2'd3; state enum ISRAM_IDLE/DELAY/RESP; the reset address constant.
- One natural sub-module: lfsr8 (clk, rst, en, seed, q). It is reusable later for data-side memory latency randomisation.
- The memory array stays inline.

Test Plan:
- Basic read:
  - Stimulus: RANDOM_DELAY=0, FIXED_DELAY=0; preload 0x80000000 <= 32'h00000413; AR 0x80000000; rready=1.
  - Response: rvalid one cycle after the handshake, rdata=32'h00000413, rresp=0.
- Backpressure:
  - Stimulus: FIXED_DELAY=3; AR 0x80000004 holding 32'hDEADBEEF; rready=0 for 5 cycles after rvalid.
  - Response: rvalid at handshake+4; rdata/rresp stable throughout; arready=0 until the cycle after rready.
- Errors:
  - AR 0x80000002 -> rresp=2, rdata=0.
  - AR 0x7FFFFFFC -> rresp=3.
  - AR 0x80004000 (DEPTH 4096) -> rresp=3.
  - Each error must still complete the handshake normally.
- Random latency:
  - Stimulus: RANDOM_DELAY=1, seed 8'hA5; 16 back-to-back fetches with rready=1.
  - Response: each latency = 1 + LFSR[1:0], matching a reference LFSR model; latency stays in 1..4; no AR is accepted while busy=1.
- Async reset mid-operation:
  - Stimulus: assert rst low in DELAY between clock edges.
  - Response: rvalid=0 and arready=0 immediately; after release, a fresh AR completes correctly; the LFSR restarts from 8'hA5.
- Preload race:
  - Stimulus: FIXED_DELAY=2; AR 0x80000008; ld_en writes 32'h12345678 there during DELAY.
  - Response: rdata=32'h12345678.
